// File: rtl/pong_draw_pkg.sv
// Shared types and constants for the pong rectangle-draw arbiter.
// Frame is 160x120; BG_COLOUR is the colour used to erase old rectangles.
package pong_draw_pkg;

    localparam int RECT_X_W   = 8;
    localparam int RECT_Y_W   = 7;
    localparam int RECT_SZ_W  = 4;
    localparam int RECT_COL_W = 3;

    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;
    localparam logic [RECT_COL_W-1:0] BG_COLOUR = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ERASE,
        DRAW,
        DONE
    } state_t;

    typedef struct packed {
        logic [RECT_X_W-1:0]   x;
        logic [RECT_Y_W-1:0]   y;
        logic [RECT_SZ_W-1:0]  w;
        logic [RECT_SZ_W-1:0]  h;
        logic [RECT_COL_W-1:0] col;
    } rect_t;

endpackage

// File: rtl/pong_draw_arbiter_if.sv
// Requester and pixel-port bundle between game-logic movers, the draw
// arbiter and the vga_adapter; master = requester/adapter side, slave = arbiter.
interface pong_draw_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int SZ_W    = 4,
    parameter int COL_W   = 3
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*X_W-1:0]   rect_x;
    logic [NUM_REQ*Y_W-1:0]   rect_y;
    logic [NUM_REQ*SZ_W-1:0]  rect_w;
    logic [NUM_REQ*SZ_W-1:0]  rect_h;
    logic [NUM_REQ*COL_W-1:0] rect_col;
    logic [NUM_REQ-1:0]       ack;
    logic                     busy;
    logic [X_W-1:0]           vga_x;
    logic [Y_W-1:0]           vga_y;
    logic [COL_W-1:0]         vga_colour;
    logic                     vga_plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_col,
        input  ack, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_col,
        output ack, busy, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/pong_rect_scanner.sv
// Scans one filled rectangle a pixel per clock, column first, with registered
// pixel outputs; off-screen pixels consume a cycle but do not plot.
module pong_rect_scanner
    import pong_draw_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  rect_t                 rect,
    output logic [RECT_X_W-1:0]   pix_x,
    output logic [RECT_Y_W-1:0]   pix_y,
    output logic [RECT_COL_W-1:0] pix_colour,
    output logic                  pix_plot,
    output logic                  pix_last
);

    localparam int SX_W = RECT_X_W + 1;
    localparam int SY_W = RECT_Y_W + 1;
    localparam logic [RECT_SZ_W-1:0] SZ_ONE = 1;
    localparam logic [SX_W-1:0]      X_LIM  = SX_W'(X_MAX);
    localparam logic [SY_W-1:0]      Y_LIM  = SY_W'(Y_MAX);

    rect_t                cur_q;
    logic [RECT_SZ_W-1:0] col_q, row_q;
    logic                 active_q;

    rect_t                base;
    logic [RECT_SZ_W-1:0] col_c, row_c, w_m1, h_m1;
    logic                 emit, at_last, at_row_end;
    logic [SX_W-1:0]      sum_x;
    logic [SY_W-1:0]      sum_y;

    // A start pulse emits the first pixel on the same edge, so the caller sees
    // pixel (0,0) one cycle after asserting start.
    always_comb begin
        base       = start ? rect : cur_q;
        col_c      = start ? '0 : col_q;
        row_c      = start ? '0 : row_q;
        emit       = start | active_q;
        w_m1       = base.w - SZ_ONE;
        h_m1       = base.h - SZ_ONE;
        at_row_end = (col_c == w_m1);
        at_last    = at_row_end && (row_c == h_m1);
        sum_x      = SX_W'(base.x) + SX_W'(col_c);
        sum_y      = SY_W'(base.y) + SY_W'(row_c);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cur_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            active_q   <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
            pix_plot   <= 1'b0;
            pix_last   <= 1'b0;
        end else begin
            pix_plot <= 1'b0;
            pix_last <= 1'b0;
            if (emit) begin
                cur_q      <= base;
                pix_x      <= sum_x[RECT_X_W-1:0];
                pix_y      <= sum_y[RECT_Y_W-1:0];
                pix_colour <= base.col;
                pix_plot   <= (sum_x <= X_LIM) && (sum_y <= Y_LIM);
                pix_last   <= at_last;
                if (at_last) begin
                    active_q <= 1'b0;
                    col_q    <= '0;
                    row_q    <= '0;
                end else if (at_row_end) begin
                    active_q <= 1'b1;
                    col_q    <= '0;
                    row_q    <= row_c + SZ_ONE;
                end else begin
                    active_q <= 1'b1;
                    col_q    <= col_c + SZ_ONE;
                    row_q    <= row_c;
                end
            end
        end
    end

endmodule

// File: rtl/pong_draw_arbiter.sv
// Round-robin arbiter sharing the vga_adapter plot port between rectangle
// requesters. Define PONG_DRAW_ERASE_EN to auto-erase each requester's previous rectangle.
module pong_draw_arbiter
    import pong_draw_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int X_W     = pong_draw_pkg::RECT_X_W,
    parameter int Y_W     = pong_draw_pkg::RECT_Y_W,
    parameter int SZ_W    = pong_draw_pkg::RECT_SZ_W,
    parameter int COL_W   = pong_draw_pkg::RECT_COL_W
) (
    input  logic                clock,
    input  logic                resetn,
    pong_draw_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_REQ - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, idx_q, sel_idx;
    logic              sel_found;
    rect_t             rect_q, scan_rect, erase_rect;
    rect_t             in_rect [NUM_REQ];
    logic              scan_start, scan_last, need_erase, draw_empty;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_rect[i].x   = bus.rect_x[i*X_W +: X_W];
            in_rect[i].y   = bus.rect_y[i*Y_W +: Y_W];
            in_rect[i].w   = bus.rect_w[i*SZ_W +: SZ_W];
            in_rect[i].h   = bus.rect_h[i*SZ_W +: SZ_W];
            in_rect[i].col = bus.rect_col[i*COL_W +: COL_W];
        end
    end

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = (int'(ptr_q) + i) % NUM_REQ;
            if (!sel_found && bus.req[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(j);
            end
        end
    end

    assign draw_empty = (rect_q.w == '0) || (rect_q.h == '0);

`ifdef PONG_DRAW_ERASE_EN
    rect_t              old_rect [NUM_REQ];
    logic [NUM_REQ-1:0] old_valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            old_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) old_rect[i] <= '0;
        end else if (state_q == DONE) begin
            old_rect[idx_q]  <= rect_q;
            old_valid[idx_q] <= 1'b1;
        end
    end

    always_comb begin
        erase_rect     = old_rect[idx_q];
        erase_rect.col = BG_COLOUR;
        need_erase     = old_valid[idx_q] && (erase_rect.w != '0) && (erase_rect.h != '0);
    end
`else
    assign erase_rect = '0;
    assign need_erase = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            rect_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && sel_found) begin
                idx_q  <= sel_idx;
                rect_q <= in_rect[sel_idx];
            end
            if (state_q == GRANT) ptr_q <= (idx_q == IDX_TOP) ? '0 : idx_q + IDX_ONE;
        end
    end

    // The scanner is restarted on the last erase pixel so DRAW follows ERASE gap-free.
    always_comb begin
        state_d    = state_q;
        scan_start = 1'b0;
        scan_rect  = rect_q;
        case (state_q)
            IDLE:  if (sel_found) state_d = GRANT;
            GRANT: begin
                if (need_erase) begin
                    scan_start = 1'b1;
                    scan_rect  = erase_rect;
                    state_d    = ERASE;
                end else if (draw_empty) begin
                    state_d = DONE;
                end else begin
                    scan_start = 1'b1;
                    state_d    = DRAW;
                end
            end
            ERASE: begin
                if (scan_last) begin
                    if (draw_empty) begin
                        state_d = DONE;
                    end else begin
                        scan_start = 1'b1;
                        state_d    = DRAW;
                    end
                end
            end
            DRAW:    if (scan_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack = '0;
        if (state_q == DONE) bus.ack[idx_q] = 1'b1;
    end

    assign bus.busy = (state_q != IDLE);

    pong_rect_scanner u_scanner (
        .clock      (clock),
        .resetn     (resetn),
        .start      (scan_start),
        .rect       (scan_rect),
        .pix_x      (bus.vga_x),
        .pix_y      (bus.vga_y),
        .pix_colour (bus.vga_colour),
        .pix_plot   (bus.vga_plot),
        .pix_last   (scan_last)
    );

endmodule

// File: tb/tb_pong_draw_arbiter.sv
// Directed bench for pong_draw_arbiter: per-cycle vector tables plus hand-written
// clipping, degenerate, abort and (with PONG_DRAW_ERASE_EN) erase sequences.
module tb_pong_draw_arbiter;

    typedef struct {
        logic [1:0] req;
        logic [1:0] ack;
        logic       busy;
        logic       plot;
        int         x;
        int         y;
        int         col;
    } vec_t;

    logic  clock;
    logic  resetn;
    int    checks;
    int    errors;
    vec_t  vecs[$];

    pong_draw_arbiter_if bus ();

    pong_draw_arbiter dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] ack, input logic busy,
                                input logic plot, input int x, input int y, input int col);
        vec_t v;
        v.req = req; v.ack = ack; v.busy = busy; v.plot = plot;
        v.x = x; v.y = y; v.col = col;
        return v;
    endfunction

    task automatic applyStimulus(input logic [1:0] req);
        bus.req = req;
    endtask

    task automatic setRect(input int idx, input int rx, input int ry, input int rw, input int rh, input int rc);
        bus.rect_x[idx*8 +: 8]   = rx[7:0];
        bus.rect_y[idx*7 +: 7]   = ry[6:0];
        bus.rect_w[idx*4 +: 4]   = rw[3:0];
        bus.rect_h[idx*4 +: 4]   = rh[3:0];
        bus.rect_col[idx*3 +: 3] = rc[2:0];
    endtask

    task automatic checkOutput(input string name, input logic [1:0] eack, input logic ebusy,
                               input logic eplot, input logic chkpix, input int ex, input int ey, input int ecol);
        checks++;
        if (bus.ack !== eack) begin
            errors++;
            $display("[TB] FAIL %s ack: got %b expected %b", name, bus.ack, eack);
        end
        checks++;
        if (bus.busy !== ebusy) begin
            errors++;
            $display("[TB] FAIL %s busy: got %b expected %b", name, bus.busy, ebusy);
        end
        checks++;
        if (bus.vga_plot !== eplot) begin
            errors++;
            $display("[TB] FAIL %s plot: got %b expected %b", name, bus.vga_plot, eplot);
        end
        if (chkpix) begin
            checks++;
            if (bus.vga_x !== 8'(ex) || bus.vga_y !== 7'(ey) || bus.vga_colour !== 3'(ecol)) begin
                errors++;
                $display("[TB] FAIL %s pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                         name, bus.vga_x, bus.vga_y, bus.vga_colour, ex, ey, ecol);
            end
        end
    endtask

    task automatic runTable(input string name);
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clock);
            checkOutput($sformatf("%s c%0d", name, k), vecs[k].ack, vecs[k].busy,
                        vecs[k].plot, vecs[k].plot, vecs[k].x, vecs[k].y, vecs[k].col);
            applyStimulus(vecs[k].req);
        end
        vecs.delete();
    endtask

    // Single requester end to end; ew=0 means no erase pass is expected.
    task automatic runSingle(input string name, input int idx, input int rx, input int ry, input int rw,
                             input int rh, input int rc, input int ex, input int ey, input int ew, input int eh);
        logic [1:0] onehot;
        int px, py;
        onehot = 2'b01 << idx;
        @(negedge clock);
        checkOutput({name, " idle"}, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        setRect(idx, rx, ry, rw, rh, rc);
        applyStimulus(onehot);
        @(negedge clock);
        checkOutput({name, " grant"}, 2'b00, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                @(negedge clock);
                px = ex + c; py = ey + r;
                checkOutput($sformatf("%s erase r%0d c%0d", name, r, c), 2'b00, 1'b1,
                            (px <= 159) && (py <= 119), (px <= 159) && (py <= 119), px, py, 0);
            end
        end
        for (int r = 0; r < rh; r++) begin
            for (int c = 0; c < rw; c++) begin
                @(negedge clock);
                px = rx + c; py = ry + r;
                checkOutput($sformatf("%s draw r%0d c%0d", name, r, c), 2'b00, 1'b1,
                            (px <= 159) && (py <= 119), (px <= 159) && (py <= 119), px, py, rc);
            end
        end
        @(negedge clock);
        checkOutput({name, " ack"}, onehot, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(2'b00);
        @(negedge clock);
        checkOutput({name, " after"}, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.req = '0;
        bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0; bus.rect_h = '0; bus.rect_col = '0;

        @(negedge clock);
        checkOutput("reset", 2'b00, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        resetn = 1'b1;

`ifdef PONG_DRAW_ERASE_EN
        runSingle("first", 0, 5, 5, 2, 2, 5, 0, 0, 0, 0);
        runSingle("move", 0, 6, 5, 2, 2, 5, 5, 5, 2, 2);
        runSingle("other first", 1, 30, 30, 1, 1, 3, 0, 0, 0, 0);
`else
        // Single 3x2 request from requester 0: ack lands at cycle 8.
        setRect(0, 10, 20, 3, 2, 4);
        setRect(1, 70, 70, 2, 2, 7);
        vecs.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b00, 1, 1, 10, 20, 4));
        vecs.push_back(mk(2'b01, 2'b00, 1, 1, 11, 20, 4));
        vecs.push_back(mk(2'b01, 2'b00, 1, 1, 12, 20, 4));
        vecs.push_back(mk(2'b01, 2'b00, 1, 1, 10, 21, 4));
        vecs.push_back(mk(2'b01, 2'b00, 1, 1, 11, 21, 4));
        vecs.push_back(mk(2'b01, 2'b00, 1, 1, 12, 21, 4));
        vecs.push_back(mk(2'b00, 2'b01, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0));
        runTable("single");

        runSingle("clip", 0, 158, 118, 4, 3, 6, 0, 0, 0, 0);
        runSingle("zero w", 1, 40, 40, 0, 3, 2, 0, 0, 0, 0);

        // Both held high: pointer is back at 0, grants go 0,1,0,1.
        setRect(0, 1, 1, 1, 1, 1);
        setRect(1, 50, 60, 2, 1, 2);
        vecs.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 1, 1, 1, 1));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 1, 50, 60, 2));
        vecs.push_back(mk(2'b11, 2'b00, 1, 1, 51, 60, 2));
        vecs.push_back(mk(2'b11, 2'b10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 1, 1, 1, 1));
        vecs.push_back(mk(2'b11, 2'b01, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b11, 2'b00, 1, 1, 50, 60, 2));
        vecs.push_back(mk(2'b11, 2'b00, 1, 1, 51, 60, 2));
        vecs.push_back(mk(2'b11, 2'b10, 1, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0));
        runTable("contend");

        // Abort: requester 0 granted (pointer moves to 1), reset hits mid-draw.
        setRect(0, 20, 20, 4, 4, 6);
        @(negedge clock);
        applyStimulus(2'b01);
        @(negedge clock);
        checkOutput("abort grant", 2'b00, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clock);
        checkOutput("abort px0", 2'b00, 1'b1, 1'b1, 1'b1, 20, 20, 6);
        @(negedge clock);
        checkOutput("abort px1", 2'b00, 1'b1, 1'b1, 1'b1, 21, 20, 6);
        @(negedge clock);
        resetn = 1'b0;
        applyStimulus(2'b00);
        #1;
        checkOutput("abort reset", 2'b00, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        @(negedge clock);
        checkOutput("abort held", 2'b00, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        resetn = 1'b1;
        setRect(0, 1, 1, 1, 1, 1);
        setRect(1, 50, 60, 2, 1, 2);
        @(negedge clock);
        checkOutput("post idle", 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(2'b11);
        @(negedge clock);
        checkOutput("post grant", 2'b00, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clock);
        checkOutput("post ptr0 px", 2'b00, 1'b1, 1'b1, 1'b1, 1, 1, 1);
        @(negedge clock);
        checkOutput("post ack", 2'b01, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        applyStimulus(2'b00);
        @(negedge clock);
        checkOutput("post idle2", 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
